// File: rtl/sopc_bus_bridge_if.sv
// Bundles the CPU data port and the shared slave bus of the SOPC data-side bridge.
// The master modport is the bridge's view; the slave modport is the CPU/slaves side.
interface sopc_bus_bridge_if #(
  parameter int NUM_SLAVES = 4
);
  logic                     cpu_ce_i;
  logic                     cpu_we_i;
  logic [31:0]              cpu_addr_i;
  logic [3:0]               cpu_sel_i;
  logic [31:0]              cpu_wdata_i;
  logic [31:0]              cpu_rdata_o;
  logic                     cpu_stall_o;
  logic                     cpu_err_o;
  logic [NUM_SLAVES-1:0]    s_ce_o;
  logic                     s_we_o;
  logic [31:0]              s_addr_o;
  logic [3:0]               s_sel_o;
  logic [31:0]              s_wdata_o;
  logic [NUM_SLAVES*32-1:0] s_rdata_i;
  logic [NUM_SLAVES-1:0]    s_ack_i;
  logic                     err_valid_o;
  logic [31:0]              err_addr_o;
  logic                     err_clr_i;

  modport master (
    input  cpu_ce_i, cpu_we_i, cpu_addr_i, cpu_sel_i, cpu_wdata_i,
    input  s_rdata_i, s_ack_i, err_clr_i,
    output cpu_rdata_o, cpu_stall_o, cpu_err_o,
    output s_ce_o, s_we_o, s_addr_o, s_sel_o, s_wdata_o,
    output err_valid_o, err_addr_o
  );

  modport slave (
    output cpu_ce_i, cpu_we_i, cpu_addr_i, cpu_sel_i, cpu_wdata_i,
    output s_rdata_i, s_ack_i, err_clr_i,
    input  cpu_rdata_o, cpu_stall_o, cpu_err_o,
    input  s_ce_o, s_we_o, s_addr_o, s_sel_o, s_wdata_o,
    input  err_valid_o, err_addr_o
  );
endinterface

// File: rtl/sopc_bus_bridge.sv
// Data-side interconnect between the CPU RAM port and NUM_SLAVES memory-mapped slaves:
// base/mask decode, stall/ack handshake with wait-state timeout, and a sticky bus-error log.
module sopc_bus_bridge #(
  parameter int                       NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*32-1:0] SLV_BASE   = {32'h2000_0000, 32'h1000_0000,
                                                    32'h0000_1000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0] SLV_MASK   = {4{32'hFFFF_F000}},
  parameter int                       TIMEOUT    = 16
) (
  input logic               clk,
  input logic               rst,
  sopc_bus_bridge_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                state;
  logic [CNT_W-1:0]      wait_cnt;
  logic [NUM_SLAVES-1:0] hit_vec;
  logic [31:0]           ack_data;
  logic                  ack_hit;
  logic                  timeout_hit;
  logic                  log_err;
  logic [31:0]           log_addr;

  // Descending scan so the lowest matching index is the one left standing on overlap.
  always_comb begin
    hit_vec = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if ((bus.cpu_addr_i & SLV_MASK[k*32 +: 32]) == SLV_BASE[k*32 +: 32])
        hit_vec = NUM_SLAVES'(1) << k;
    end
    ack_data = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (bus.s_ce_o[k])
        ack_data = ack_data | bus.s_rdata_i[k*32 +: 32];
    end
  end

  assign ack_hit     = |(bus.s_ce_o & bus.s_ack_i);
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign log_err     = ((state == IDLE) && bus.cpu_ce_i && (hit_vec == '0)) ||
                       ((state == ACCESS) && !ack_hit && timeout_hit);
  assign log_addr    = (state == IDLE) ? bus.cpu_addr_i : bus.s_addr_o;

  assign bus.cpu_stall_o = (state == IDLE) ? bus.cpu_ce_i : (state == ACCESS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      wait_cnt        <= '0;
      bus.s_ce_o      <= '0;
      bus.s_we_o      <= 1'b0;
      bus.s_addr_o    <= '0;
      bus.s_sel_o     <= '0;
      bus.s_wdata_o   <= '0;
      bus.cpu_rdata_o <= '0;
      bus.cpu_err_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_ce_i) begin
            bus.s_we_o    <= bus.cpu_we_i;
            bus.s_addr_o  <= bus.cpu_addr_i;
            bus.s_sel_o   <= bus.cpu_sel_i;
            bus.s_wdata_o <= bus.cpu_wdata_i;
            wait_cnt      <= '0;
            if (hit_vec != '0) begin
              bus.s_ce_o <= hit_vec;
              state      <= ACCESS;
            end else begin
              bus.cpu_rdata_o <= '0;
              bus.cpu_err_o   <= 1'b1;
              state           <= DONE;
            end
          end
        end
        ACCESS: begin
          if (ack_hit) begin
            // Writes hand back zero so the CPU never sees stale slave data.
            bus.cpu_rdata_o <= bus.s_we_o ? 32'h0 : ack_data;
            bus.cpu_err_o   <= 1'b0;
            bus.s_ce_o      <= '0;
            state           <= DONE;
          end else if (timeout_hit) begin
            bus.cpu_rdata_o <= '0;
            bus.cpu_err_o   <= 1'b1;
            bus.s_ce_o      <= '0;
            state           <= DONE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // First error since the last clear is kept; a clear coinciding with a new error logs the new one.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.err_valid_o <= 1'b0;
      bus.err_addr_o  <= '0;
    end else if (log_err && (!bus.err_valid_o || bus.err_clr_i)) begin
      bus.err_valid_o <= 1'b1;
      bus.err_addr_o  <= log_addr;
    end else if (bus.err_clr_i) begin
      bus.err_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sopc_bus_bridge.sv
// Randomised self-checking bench for sopc_bus_bridge against a transaction-level reference model.
module tb_sopc_bus_bridge;

  localparam int                TO  = 16;
  localparam int                NS  = 4;
  localparam logic [NS*32-1:0]  BASES = {32'h1000_0000, 32'h1000_0000, 32'h0000_1000, 32'h0000_0000};
  localparam logic [NS*32-1:0]  MASKS = {32'hF000_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000};

  logic clk = 1'b0;
  logic rst = 1'b1;

  int nCompared   = 0;
  int nMismatched = 0;

  logic        mErrValid = 1'b0;
  logic [31:0] mErrAddr  = 32'h0;

  sopc_bus_bridge_if #(.NUM_SLAVES(NS)) bus ();

  sopc_bus_bridge #(
    .NUM_SLAVES(NS),
    .SLV_BASE  (BASES),
    .SLV_MASK  (MASKS),
    .TIMEOUT   (TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Reference decode: first slave (ascending index) whose masked address equals its base.
  function automatic int refDecode(input logic [31:0] addr);
    for (int k = 0; k < NS; k++)
      if ((addr & MASKS[k*32 +: 32]) == BASES[k*32 +: 32]) return k;
    return -1;
  endfunction

  // One CPU access; lat is the ACCESS cycle in which the slave acks (> TO means never).
  task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic [3:0] sel,
                               input logic [31:0] wdata, input int lat, input logic clr);
    int          k;
    int          n;
    logic        last;
    logic        expErr;
    logic [31:0] expData;
    k       = refDecode(addr);
    expErr  = (k < 0);
    expData = 32'h0;
    bus.cpu_ce_i    = 1'b1;
    bus.cpu_we_i    = we;
    bus.cpu_addr_i  = addr;
    bus.cpu_sel_i   = sel;
    bus.cpu_wdata_i = wdata;
    bus.err_clr_i   = (k < 0) ? clr : 1'b0;
    #1 checkOutput("req_stall", 32'(bus.cpu_stall_o), 32'd1);
    @(posedge clk); #1;
    if (k >= 0) begin
      n    = 0;
      last = 1'b0;
      while (!last) begin
        n++;
        last = (n == lat) || (n == TO);
        checkOutput("acc_ce", 32'(bus.s_ce_o), 32'(4'b0001 << k));
        checkOutput("acc_stall", 32'(bus.cpu_stall_o), 32'd1);
        checkOutput("acc_wdata", bus.s_wdata_o, wdata);
        if (n == 1) begin
          checkOutput("acc_addr", bus.s_addr_o, addr);
          checkOutput("acc_we", 32'(bus.s_we_o), 32'(we));
          checkOutput("acc_sel", 32'(bus.s_sel_o), 32'(sel));
        end
        bus.s_rdata_i = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.s_ack_i   = 4'($urandom()) & ~(4'b0001 << k);
        if (n == lat) begin
          bus.s_ack_i[k] = 1'b1;
          expData = we ? 32'h0 : bus.s_rdata_i[k*32 +: 32];
        end
        bus.err_clr_i = last ? clr : 1'b0;
        @(posedge clk); #1;
      end
      expErr = (lat > TO);
    end
    bus.s_ack_i   = '0;
    bus.err_clr_i = 1'b0;
    if (expErr && (!mErrValid || clr)) begin
      mErrValid = 1'b1;
      mErrAddr  = addr;
    end else if (clr) begin
      mErrValid = 1'b0;
    end
    checkOutput("done_stall", 32'(bus.cpu_stall_o), 32'd0);
    checkOutput("done_ce", 32'(bus.s_ce_o), 32'd0);
    checkOutput("done_err", 32'(bus.cpu_err_o), 32'(expErr));
    checkOutput("done_rdata", bus.cpu_rdata_o, expData);
    checkOutput("err_valid", 32'(bus.err_valid_o), 32'(mErrValid));
    checkOutput("err_addr", bus.err_addr_o, mErrAddr);
    @(posedge clk); #1;
    bus.cpu_ce_i = 1'b0;
    #1 checkOutput("idle_stall", 32'(bus.cpu_stall_o), 32'd0);
    checkOutput("idle_ce", 32'(bus.s_ce_o), 32'd0);
  endtask

  function automatic logic [31:0] randAddr();
    case ($urandom_range(0, 4))
      0:       return {20'h00000, 12'($urandom())};
      1:       return {20'h00001, 12'($urandom())};
      2:       return {20'h10000, 12'($urandom())};
      3:       return {4'h1, 28'($urandom())};
      default: return {4'($urandom_range(2, 15)), 28'($urandom())};
    endcase
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.cpu_ce_i    = 1'b0;
    bus.cpu_we_i    = 1'b0;
    bus.cpu_addr_i  = '0;
    bus.cpu_sel_i   = '0;
    bus.cpu_wdata_i = '0;
    bus.s_rdata_i   = '0;
    bus.s_ack_i     = '0;
    bus.err_clr_i   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ce", 32'(bus.s_ce_o), 32'd0);
    checkOutput("rst_stall", 32'(bus.cpu_stall_o), 32'd0);
    checkOutput("rst_cpu_err", 32'(bus.cpu_err_o), 32'd0);
    checkOutput("rst_rdata", bus.cpu_rdata_o, 32'd0);
    checkOutput("rst_err_valid", 32'(bus.err_valid_o), 32'd0);
    checkOutput("rst_err_addr", bus.err_addr_o, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(32'h0000_0010, 1'b0, 4'hF, 32'h0, 1, 1'b0);
    applyStimulus(32'h1000_0004, 1'b1, 4'b0011, 32'hA5A5_A5A5, 3, 1'b0);
    applyStimulus(32'h8000_0000, 1'b0, 4'hF, 32'h0, 1, 1'b0);
    applyStimulus(32'h0000_1000, 1'b0, 4'hF, 32'h0, 99, 1'b0);
    applyStimulus(32'h0000_1004, 1'b0, 4'hF, 32'h0, 99, 1'b0);
    applyStimulus(32'h0000_1008, 1'b0, 4'hF, 32'h0, TO, 1'b0);
    applyStimulus(32'h9000_0040, 1'b0, 4'hF, 32'h0, 1, 1'b1);
    applyStimulus(32'h1000_0008, 1'b0, 4'hF, 32'h0, 2, 1'b1);
    applyStimulus(32'h1234_0000, 1'b0, 4'hF, 32'h0, 5, 1'b0);

    // Reset during the third ACCESS cycle, then a late ack that must be ignored.
    bus.cpu_ce_i   = 1'b1;
    bus.cpu_we_i   = 1'b0;
    bus.cpu_addr_i = 32'h0000_1010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.cpu_ce_i = 1'b0;
    bus.s_ack_i  = 4'b0010;
    mErrValid = 1'b0;
    mErrAddr  = 32'h0;
    #1 checkOutput("rst_mid_ce", 32'(bus.s_ce_o), 32'd0);
    checkOutput("rst_mid_stall", 32'(bus.cpu_stall_o), 32'd0);
    @(posedge clk); #1;
    bus.s_ack_i = '0;
    checkOutput("late_ack_stall", 32'(bus.cpu_stall_o), 32'd0);
    checkOutput("late_ack_err", 32'(bus.cpu_err_o), 32'd0);
    checkOutput("late_ack_rdata", bus.cpu_rdata_o, 32'd0);
    checkOutput("late_ack_err_valid", 32'(bus.err_valid_o), 32'd0);

    for (int i = 0; i < 80; i++) begin
      applyStimulus(randAddr(), 1'($urandom()), 4'($urandom()), $urandom(),
                    $urandom_range(1, TO + 4), ($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
